// File: rtl/m_uart_report.sv
// ---------------------------------------------------------------------------
// m_uart_report
//
// When the processor raises its halt flag, this block snapshots the result
// value and the cycle counter, then sends them over a UART TX line as the
// ASCII report "RRRRRRRR CCCCCCCC\r\n": 19 bytes, uppercase hex, MSB nibble
// first, framed 8N1 with no gap between bytes.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (2..65535)
//
// Ports:
//   w_clk   in   system clock
//   w_rst   in   asynchronous active-high reset (aborts a frame immediately)
//   w_halt  in   processor halt flag (level); its rising edge starts a report
//   w_rout  in   [31:0] processor result value, sampled at the trigger edge
//   w_cnt   in   [31:0] cycle counter value, sampled at the trigger edge
//   r_txd   out  UART serial output, idle high, registered
//   r_busy  out  high while a report is in flight
//   r_done  out  high once a report has completed (sticky until next trigger)
// ---------------------------------------------------------------------------
module m_uart_report #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_halt,
    input  logic [31:0] w_rout,
    input  logic [31:0] w_cnt,
    output logic        r_txd,
    output logic        r_busy,
    output logic        r_done
);

    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t      state_reg,     state_next;
    logic [15:0] baud_reg,      baud_next;
    logic [2:0]  bit_cnt_reg,   bit_cnt_next;
    logic [4:0]  byte_idx_reg,  byte_idx_next;
    logic [31:0] snap_rout_reg, snap_rout_next;
    logic [31:0] snap_cnt_reg,  snap_cnt_next;
    logic        halt_d_reg;
    logic        txd_reg,       txd_next;
    logic        busy_reg,      busy_next;
    logic        done_reg,      done_next;

    logic        trigger;
    logic        bit_end;
    logic [7:0]  cur_byte;
    logic [2:0]  cnt_sel;
    logic [2:0]  bit_cnt_inc;

    // Hex characters of every snapshot nibble, index 0 = most significant.
    logic [7:0]  rout_hex [8];
    logic [7:0]  cnt_hex  [8];

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        // 'A' - 10 = 0x37, so letters need no separate subtraction.
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nib
            assign rout_hex[gi] = hex_char(snap_rout_reg[31 - 4*gi -: 4]);
            assign cnt_hex[gi]  = hex_char(snap_cnt_reg[31 - 4*gi -: 4]);
        end
    endgenerate

    // Byte indices 9..16 carry the counter; their low three bits minus one
    // (mod 8) give nibble 0..7 directly (9 -> 0, ..., 16 -> 7).
    assign cnt_sel = byte_idx_reg[2:0] - 3'd1;

    always_comb begin
        cur_byte = 8'h0A;
        if (byte_idx_reg < 5'd8)
            cur_byte = rout_hex[byte_idx_reg[2:0]];
        else if (byte_idx_reg == 5'd8)
            cur_byte = 8'h20;
        else if (byte_idx_reg <= 5'd16)
            cur_byte = cnt_hex[cnt_sel];
        else if (byte_idx_reg == 5'd17)
            cur_byte = 8'h0D;
    end

    assign trigger     = w_halt && !halt_d_reg &&
                         (state_reg == S_IDLE || state_reg == S_DONE);
    assign bit_end     = (baud_reg == BAUD_MAX);
    assign bit_cnt_inc = bit_cnt_reg + 3'd1;

    always_comb begin
        state_next     = state_reg;
        baud_next      = baud_reg;
        bit_cnt_next   = bit_cnt_reg;
        byte_idx_next  = byte_idx_reg;
        snap_rout_next = snap_rout_reg;
        snap_cnt_next  = snap_cnt_reg;
        txd_next       = txd_reg;
        busy_next      = busy_reg;
        done_next      = done_reg;

        case (state_reg)
            S_IDLE, S_DONE: begin
                txd_next = 1'b1;
                if (trigger) begin
                    snap_rout_next = w_rout;
                    snap_cnt_next  = w_cnt;
                    baud_next      = 16'd0;
                    bit_cnt_next   = 3'd0;
                    byte_idx_next  = 5'd0;
                    state_next     = S_START;
                    txd_next       = 1'b0;
                    busy_next      = 1'b1;
                    done_next      = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_next    = 16'd0;
                    bit_cnt_next = 3'd0;
                    state_next   = S_DATA;
                    txd_next     = cur_byte[0];
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_next = 16'd0;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = S_STOP;
                        txd_next   = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt_inc;
                        txd_next     = cur_byte[bit_cnt_inc];
                    end
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_next = 16'd0;
                    if (byte_idx_reg == 5'd18) begin
                        state_next = S_DONE;
                        txd_next   = 1'b1;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        // Next start bit follows immediately: no idle gap.
                        byte_idx_next = byte_idx_reg + 5'd1;
                        state_next    = S_START;
                        txd_next      = 1'b0;
                    end
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
                txd_next   = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_reg     <= S_IDLE;
            baud_reg      <= 16'd0;
            bit_cnt_reg   <= 3'd0;
            byte_idx_reg  <= 5'd0;
            snap_rout_reg <= 32'd0;
            snap_cnt_reg  <= 32'd0;
            halt_d_reg    <= 1'b0;
            txd_reg       <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            baud_reg      <= baud_next;
            bit_cnt_reg   <= bit_cnt_next;
            byte_idx_reg  <= byte_idx_next;
            snap_rout_reg <= snap_rout_next;
            snap_cnt_reg  <= snap_cnt_next;
            halt_d_reg    <= w_halt;
            txd_reg       <= txd_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign r_txd  = txd_reg;
    assign r_busy = busy_reg;
    assign r_done = done_reg;

endmodule
